mram_burst_arb: RTL
===================

Name: mram_burst_arb

Overview:
- Two-port scheduler that shares the single SPI MRAM transfer engine, and its burst address datapath, between two requesters (e.g. host bridge and test/DMA port).
- Arbitrates round-robin, latches the winner's start address, length and direction, then issues one command and sequences per-word addresses until the burst completes.
- Sits between the requester logic and the existing burst/SPI serializer path.

Parameters:
- ADDR_W, 24, MRAM word address width.
- LEN_W, 8, burst length width (number of words, 1..2^LEN_W-1).
- TMO_W, 10, width of the word-stall timeout counter (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request, level; held until done.
- req_wr  in  2  per-requester direction, 1 = write.
- req_addr0  in  ADDR_W  requester 0 start address.
- req_addr1  in  ADDR_W  requester 1 start address.
- req_len0  in  LEN_W  requester 0 word count.
- req_len1  in  LEN_W  requester 1 word count.
- gnt  out  2  one-hot grant, held for the whole burst.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  2  one-cycle error pulse, coincident with done.
- cmd_valid  out  1  command to engine valid.
- cmd_ready  in  1  engine accepts command.
- cmd_wr  out  1  command direction.
- cmd_addr  out  ADDR_W  burst start address.
- word_valid  out  1  current word address valid.
- word_ready  in  1  engine finished current word.
- word_addr  out  ADDR_W  current word address.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0, state IDLE, round-robin pointer selects requester 0 first, counters 0.
- States: IDLE, ISSUE, XFER, FIN.
- IDLE:
  - When any req bit is set, pick the winner: the pointer's side if it is requesting, else the other side.
  - Latch the winner's addr, len and wr; set gnt on the next edge.
  - len==0: go to FIN with err set; no command is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - cmd_valid=1 with cmd_addr and cmd_wr stable.
  - On cmd_valid&&cmd_ready, go to XFER next cycle with word_addr=start and remaining=len.
- XFER:
  - word_valid=1.
  - On word_ready, decrement remaining and increment word_addr modulo 2^ADDR_W (0xFFFFFF wraps to 0x000000).
  - When remaining==1 and word_ready, deassert word_valid and go to FIN.
- FIN:
  - done (and err if flagged) pulse for one cycle on the gnt side.
  - gnt drops the same cycle.
  - The pointer moves to the other requester.
  - Return to IDLE; the next grant is possible no earlier than the following cycle.
- Grant latency: req rising in IDLE gives gnt and cmd_valid one cycle later.
- Minimum burst of 1 word: IDLE, ISSUE (1+ cycles), XFER (1+ cycles), FIN.
- Simultaneous requests: the pointer wins. The loser is served next, provided it is still requesting.
- Request dropped mid-burst: ignored; the burst completes and done still pulses.
- Request re-asserted in the FIN cycle: not seen until IDLE.
- Back-to-back word_ready: one word per cycle; no bubbles are inserted by the arbiter.
- Latched fields are immune to changes on the req_* inputs after the grant.
- rst mid-burst: immediate return to reset values. No done pulse is issued.

Optional Feature:
- MRAM_ARB_TIMEOUT_EN defined:
  - In ISSUE and XFER, a TMO_W-bit counter counts cycles without the awaited ready; it clears on each handshake.
  - On reaching all-ones, abort to FIN with err=1 and done=1, then rotate the pointer.
- Not defined: no counter is present and the arbiter waits indefinitely; err occurs only for len==0.

Decomposition:
- Shared package mram_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, XFER=2'd2, FIN=2'd3);
  - requester index constants REQ_HOST=0 and REQ_AUX=1;
  - default ADDR_W and LEN_W.
- One natural sub-module, mram_rr_pick: a combinational round-robin winner select from the req and pointer inputs.
- Address incrementer and length countdown stay inline.

Test Plan:
- Single request: req0=1, addr0=0x000100, len0=4, cmd_ready immediate, word_ready every cycle → gnt=01, cmd_addr=0x000100, word_addr 0x100..0x103, done[0] pulse, err=0.
- Contention: req=11 from reset → requester 0 served first, then requester 1 without deasserting req1; pointer alternates over 4 bursts.
- Wrap: addr1=0xFFFFFE, len1=4 → word_addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Zero length: len0=0 → no cmd_valid, done[0]=1 and err[0]=1 two cycles after req.
- Stalls and reset: word_ready held low 5 cycles mid-burst → word_addr stable; then rst pulse mid-XFER → all outputs 0 and no done.
- MRAM_ARB_TIMEOUT_EN, TMO_W=4: cmd_ready held 0 → err and done pulse after 15 stalled cycles; next requester granted.

Source files
------------

// File: rtl/mram_pkg.sv
// -----------------------------------------------------------------------------
// mram_pkg
// Shared definitions for the MRAM burst arbiter slice.
//   - Arbiter state encoding (IDLE, ISSUE, XFER, FIN)
//   - Requester index constants (REQ_HOST, REQ_AUX)
//   - Default address, length and timeout counter widths
//   - onehot2: converts a requester index into a one-hot grant vector
// -----------------------------------------------------------------------------
package mram_pkg;

    localparam int MRAM_ADDR_W = 24;
    localparam int MRAM_LEN_W  = 8;
    localparam int MRAM_TMO_W  = 10;

    localparam int REQ_HOST = 0;
    localparam int REQ_AUX  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        FIN   = 2'd3
    } arb_state_t;

    // Grant vectors are always one-hot over the two requesters, so the
    // winner index is enough to rebuild the grant.
    function automatic logic [1:0] onehot2(input logic idx);
        logic [1:0] vec;
        vec = 2'b00;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mram_rr_pick.sv
// -----------------------------------------------------------------------------
// mram_rr_pick
// Combinational two-way round-robin winner select.
// Ports:
//   req    in  2  request vector (bit REQ_HOST, bit REQ_AUX)
//   ptr    in  1  requester that has priority this round
//   any    out 1  at least one requester is asking
//   winner out 1  index of the selected requester (valid when any=1)
// -----------------------------------------------------------------------------
module mram_rr_pick
    import mram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       any,
    output logic       winner
);

    // The priority side wins whenever it is asking; otherwise the grant
    // falls to the other side, which must then be the one requesting.
    always_comb begin
        any    = req[REQ_HOST] | req[REQ_AUX];
        winner = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/mram_burst_arb.sv
// -----------------------------------------------------------------------------
// mram_burst_arb
// Shares one SPI MRAM transfer engine between two requesters. A round-robin
// winner is granted, its start address / length / direction are latched, one
// command is handed to the engine and then per-word addresses are sequenced
// until the burst completes.
//
// Optional feature: define MRAM_ARB_TIMEOUT_EN to add a stall timeout. A
// TMO_W-bit counter tracks cycles spent waiting for cmd_ready / word_ready;
// when it reaches all-ones the burst is aborted with err and done.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req[1:0], req_wr[1:0] per-requester request level and direction
//   req_addr0/1           start word address per requester
//   req_len0/1            word count per requester (0 is flagged as error)
//   gnt[1:0]              one-hot grant, held for the burst
//   done[1:0], err[1:0]   one-cycle completion / error pulses
//   cmd_valid/ready       command handshake; cmd_wr, cmd_addr payload
//   word_valid/ready      per-word handshake; word_addr payload
//   busy                  arbiter is not idle
// -----------------------------------------------------------------------------
module mram_burst_arb
    import mram_pkg::*;
#(
    parameter int ADDR_W = MRAM_ADDR_W,
    parameter int LEN_W  = MRAM_LEN_W,
    parameter int TMO_W  = MRAM_TMO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [ADDR_W-1:0] word_addr,
    output logic              busy
);

    arb_state_t        state;
    logic              ptr;
    logic              cur;
    logic              err_flag;
    logic [LEN_W-1:0]  remaining;

    logic              pick_any;
    logic              pick_win;
    logic [ADDR_W-1:0] pick_addr;
    logic [LEN_W-1:0]  pick_len;

    if (TMO_W < 1) begin : g_bad_tmo_w
        $error("mram_burst_arb: TMO_W must be at least 1");
    end

`ifdef MRAM_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;
    logic [TMO_W-1:0] tmo_cnt;
`endif

    mram_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_win)
    );

    // Steer the winner's request fields so IDLE can latch them in one step.
    always_comb begin
        pick_addr = pick_win ? req_addr1 : req_addr0;
        pick_len  = pick_win ? req_len1  : req_len0;
    end

    // Busy is a pure decode of the state register, so it stays glitch-free.
    always_comb begin
        busy = (state != IDLE);
    end

    // Main burst sequencer. All outputs are registered here; done/err default
    // to zero every cycle so they can only ever be single-cycle pulses. The
    // request fields are sampled only in IDLE, which is what makes the burst
    // immune to later changes on the req_* inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cur        <= 1'b0;
            err_flag   <= 1'b0;
            remaining  <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            cmd_valid  <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            word_valid <= 1'b0;
            word_addr  <= '0;
`ifdef MRAM_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
`ifdef MRAM_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (pick_any) begin
                        cur       <= pick_win;
                        gnt       <= onehot2(pick_win);
                        cmd_addr  <= pick_addr;
                        cmd_wr    <= req_wr[pick_win];
                        remaining <= pick_len;
                        if (pick_len == '0) begin
                            err_flag <= 1'b1;
                            state    <= FIN;
                        end else begin
                            err_flag  <= 1'b0;
                            cmd_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid  <= 1'b0;
                        word_valid <= 1'b1;
                        word_addr  <= cmd_addr;
                        state      <= XFER;
`ifdef MRAM_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cmd_valid <= 1'b0;
                        err_flag  <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                XFER: begin
                    if (word_ready) begin
`ifdef MRAM_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (remaining == LEN_W'(1)) begin
                            word_valid <= 1'b0;
                            state      <= FIN;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                            word_addr <= word_addr + ADDR_W'(1);
                        end
`ifdef MRAM_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        word_valid <= 1'b0;
                        err_flag   <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                FIN: begin
                    done     <= gnt;
                    err      <= err_flag ? gnt : 2'b00;
                    gnt      <= '0;
                    ptr      <= ~cur;
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
